ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the pipelined MIPS core.
- Executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers, and services MTHI/MTLO.
- Drives stall_o, which is wired to the remain input of the IF/ID and ID/EX pipe registers, so the issuing instruction holds in EX until the result is committed.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk_i  input  1  system clock, rising edge.
rst_i  input  1  synchronous active-low reset.
start_i  input  1  EX-stage instruction is a mul/div op; held high while stalled.
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
rs_data_i  input  WIDTH  multiplicand or dividend.
rt_data_i  input  WIDTH  multiplier or divisor.
flush_i  input  1  abort the in-flight op (branch or exception flush of EX).
mthi_i  input  1  write rs_data_i to HI.
mtlo_i  input  1  write rs_data_i to LO.
stall_o  output  1  pipeline hold, drives Pipe_Reg remain.
done_o  output  1  one-cycle pulse: HI/LO hold the new result.
hi_o  output  WIDTH  HI register.
lo_o  output  WIDTH  LO register.

Behaviour:
- Reset: all of the following are cleared on the first rising edge with rst_i=0, regardless of state, and any in-flight op is discarded:
  - state=IDLE
  - hi_o=0, lo_o=0
  - done_o=0, stall_o=0
  - counter=0, internal operand/accumulator registers=0
- FSM states: IDLE, CALC, SIGN, DONE.
  - IDLE -> CALC: when start_i=1 and flush_i=0. On that edge, latch operand magnitudes, latch signs (signed ops only, MSB-based), latch op, counter=0.
  - CALC: one bit per cycle.
    - Multiply: shift-add, 2*WIDTH product.
    - Divide: restoring, WIDTH quotient and WIDTH remainder.
    - After the WIDTH-th iteration (counter==WIDTH-1), go to SIGN.
  - SIGN: one cycle.
    - Apply sign correction: product negated if sa^sb; quotient negated if sa^sb; remainder negated if sa.
    - Write HI/LO on the exit edge. Multiply: HI=upper half, LO=lower half. Divide: HI=remainder, LO=quotient.
    - Go to DONE.
  - DONE: one cycle. done_o=1, start_i ignored, unconditionally return to IDLE.
- stall_o is combinational: stall_o = (IDLE & start_i & ~flush_i) | CALC | SIGN.
  - stall_o is 0 in DONE, so the pipe registers advance on the edge ending DONE.
  - The instruction therefore spends WIDTH+3 cycles in EX, with WIDTH+2 stalled cycles (34 for WIDTH=32).
- Divide by zero: no trap. HI=rs_data_i (dividend), LO=all ones. Still takes the full latency.
- Signed DIV of most-negative by -1: LO=0x80000000, HI=0. Natural wrap, no exception.
- Signed remainder takes the dividend's sign.
- flush_i:
  - In CALC or SIGN: return to IDLE next edge; HI/LO unchanged; stall_o drops combinationally in the flush cycle.
  - In IDLE: blocks the start.
  - In DONE: no effect (result already committed).
- mthi_i/mtlo_i:
  - Honored only in IDLE or DONE; written at the edge.
  - If written in the same DONE cycle as a result, the MT write wins for that register.
  - Ignored while busy; the pipeline is stalled then, so the case does not arise architecturally.
- Operand inputs are sampled only on the IDLE->CALC edge; later changes have no effect.
- HI/LO change only on the SIGN exit edge, on MT writes, or on reset.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, start held until stall_o falls -> stall_o high exactly 34 cycles, done_o pulses once, HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=7, rt=0 -> HI=0x00000007, LO=0xFFFFFFFF, full latency, no hang.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO; start DIVU 100/3; assert flush_i in the 10th CALC cycle -> state IDLE next cycle, stall_o=0, HI=0x11 and LO=0x22 unchanged, done_o never pulses.
- Start MULTU 6*7; drive rst_i=0 for one cycle mid-CALC -> all outputs 0 on that edge; with start_i held, a fresh op starts after reset and yields LO=42, HI=0.
- Back-to-back: second MULTU 2*3 presented in the DONE cycle of a prior op -> ignored in DONE, accepted the next cycle in IDLE, LO=6 after 34 further stall cycles.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             flush_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic               r_sa, r_sb;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_start, w_sa, w_sb, w_neg;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_res_hi, w_res_lo;
  logic [WIDTH:0]     w_add, w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_step, w_prod;

  assign w_start = start_i & ~flush_i;
  assign w_sa    = ~op_i[0] & rs_data_i[WIDTH-1];
  assign w_sb    = ~op_i[0] & rt_data_i[WIDTH-1];
  assign w_mag_a = w_sa ? -rs_data_i : rs_data_i;
  assign w_mag_b = w_sb ? -rt_data_i : rt_data_i;

  // Multiply: shift-add into the upper half. Divide: restoring, quotient bits enter at bit 0.
  assign w_add    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_step   = !r_op[1] ? {w_add, r_acc[WIDTH-1:1]} :
                    w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                                    {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // A zero divisor keeps the all-ones quotient regardless of operand signs.
  assign w_neg    = r_sa ^ r_sb;
  assign w_prod   = w_neg ? -r_acc : r_acc;
  assign w_quo    = (w_neg && r_b != '0) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_res_hi = r_op[1] ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_op[1] ? w_quo : w_prod[WIDTH-1:0];

  // A flush releases the pipeline in the same cycle it is raised.
  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next  = CALC;
          stall_o = 1'b1;
        end
      end
      CALC: begin
        if (flush_i) begin
          w_next = IDLE;
        end else begin
          stall_o = 1'b1;
          if (r_cnt == C_LAST) w_next = SIGN;
        end
      end
      SIGN: begin
        if (flush_i) begin
          w_next = IDLE;
        end else begin
          stall_o = 1'b1;
          w_next  = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_op  <= op_i;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_a   <= w_mag_a;
            r_b   <= w_mag_b;
            r_acc <= {{WIDTH{1'b0}}, (op_i[1] ? w_mag_a : w_mag_b)};
            r_cnt <= '0;
          end
        end
        CALC: begin
          if (!flush_i) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SIGN: begin
          if (!flush_i) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        default: ;
      endcase
      if (r_state == IDLE || r_state == DONE) begin
        if (mthi_i) r_hi <= rs_data_i;
        if (mtlo_i) r_lo <= rs_data_i;
      end
    end
  end

  assign done_o = (r_state == DONE);
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Directed self-checking bench for ex_muldiv_unit with a latency model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] rs, rt;
  logic         stall, done;
  logic [W-1:0] hi, lo;

  int           errors = 0;
  int           checks = 0;
  bit           chk_en = 1'b0;

  int           m_cnt = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [63:0]  m_res = '0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .op_i      (op),
    .rs_data_i (rs),
    .rt_data_i (rt),
    .flush_i   (flush),
    .mthi_i    (mthi),
    .mtlo_i    (mtlo),
    .stall_o   (stall),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  // Architectural result as {HI, LO}.
  function automatic logic [63:0] ref_result(input logic [1:0] f_op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    case (f_op)
      2'd0: r = sa * sb;
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: m_cnt counts cycles since acceptance; result lands after W+1 busy cycles.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_cnt = 0;
      m_hi  = '0;
      m_lo  = '0;
    end else if (m_cnt == 0) begin
      if (start && !flush) begin
        m_cnt = 1;
        m_res = ref_result(op, rs, rt);
      end
      if (mthi) m_hi = rs;
      if (mtlo) m_lo = rs;
    end else if (m_cnt <= W + 1) begin
      if (flush) m_cnt = 0;
      else if (m_cnt == W + 1) begin
        m_hi  = m_res[63:32];
        m_lo  = m_res[31:0];
        m_cnt = W + 2;
      end else m_cnt++;
    end else begin
      if (mthi) m_hi = rs;
      if (mtlo) m_lo = rs;
      m_cnt = 0;
    end
  end

  initial forever begin
    logic exp_stall;
    @(negedge clk);
    if (chk_en) begin
      exp_stall = (m_cnt == 0 && start && !flush) || (m_cnt >= 1 && m_cnt <= W + 1 && !flush);
      check("stall_o", 64'(stall), 64'(exp_stall));
      check("done_o", 64'(done), 64'(m_cnt == W + 2));
      check("hi_o", 64'(hi), 64'(m_hi));
      check("lo_o", 64'(lo), 64'(m_lo));
    end
  end

  task automatic present(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    rs    = a;
    rt    = b;
    start = 1'b1;
  endtask

  // Returns at the negedge of the first cycle with stall_o low.
  task automatic wait_free(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) begin
        check("done_at_release", 64'(done), 64'd1);
        return;
      end
      n++;
    end
    checks++;
    errors++;
    $display("FAIL timeout: stall_o high for %0d cycles, required release", n);
  endtask

  task automatic release_op();
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    // MULTU max*max with stall-length measurement
    next_cycle();
    present(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_free(n);
    check("multu_stall_cycles", 64'(n), 64'd34);
    release_op();
    @(negedge clk);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);
    check("multu_done_once", 64'(done), 64'd0);

    // MULT -3*5, then DIV -7/2
    next_cycle();
    present(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_free(n);
    release_op();
    @(negedge clk);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    next_cycle();
    present(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_free(n);
    release_op();
    @(negedge clk);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);

    // DIVU by zero, then MTHI in the DONE cycle overrides the fresh HI
    next_cycle();
    present(2'd3, 32'd7, 32'd0);
    wait_free(n);
    check("divu0_stall_cycles", 64'(n), 64'd34);
    check("divu0_hi", 64'(hi), 64'h0000_0007);
    check("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
    #1;
    mthi = 1'b1;
    rs   = 32'h0000_ABCD;
    release_op();
    @(negedge clk);
    check("mthi_in_done_hi", 64'(hi), 64'h0000_ABCD);
    check("mthi_in_done_lo", 64'(lo), 64'hFFFF_FFFF);

    // Signed corner cases: most-negative / -1 and signed divide by zero
    next_cycle();
    present(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_free(n);
    release_op();
    @(negedge clk);
    check("div_ovf_hi", 64'(hi), 64'h0000_0000);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    next_cycle();
    present(2'd2, 32'hFFFF_FFFB, 32'd0);
    wait_free(n);
    release_op();
    @(negedge clk);
    check("div0_signed_hi", 64'(hi), 64'hFFFF_FFFB);
    check("div0_signed_lo", 64'(lo), 64'hFFFF_FFFF);

    // Preload HI/LO, start DIVU 100/3, flush in the 10th CALC cycle
    next_cycle();
    mthi = 1'b1; rs = 32'h11;
    next_cycle();
    mthi = 1'b0; mtlo = 1'b1; rs = 32'h22;
    next_cycle();
    mtlo = 1'b0;
    present(2'd3, 32'd100, 32'd3);
    repeat (10) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall_drop", 64'(stall), 64'd0);
    next_cycle();
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("flush_idle_stall", 64'(stall), 64'd0);
    repeat (40) next_cycle();
    @(negedge clk);
    check("flush_hi_kept", 64'(hi), 64'h11);
    check("flush_lo_kept", 64'(lo), 64'h22);

    // Reset mid-CALC with start held; a fresh op follows
    next_cycle();
    present(2'd1, 32'd6, 32'd7);
    repeat (5) next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    wait_free(n);
    check("rst_restart_stall_cycles", 64'(n + 1), 64'd34);
    release_op();
    @(negedge clk);
    check("rst_restart_lo", 64'(lo), 64'd42);
    check("rst_restart_hi", 64'(hi), 64'd0);

    // Back-to-back: next op presented during DONE is taken only in IDLE
    next_cycle();
    present(2'd1, 32'd5, 32'd9);
    wait_free(n);
    check("b2b_first_lo", 64'(lo), 64'd45);
    #1;
    present(2'd1, 32'd2, 32'd3);
    wait_free(n);
    check("b2b_second_stall_cycles", 64'(n), 64'd34);
    check("b2b_second_lo", 64'(lo), 64'd6);
    release_op();
    @(negedge clk);
    check("b2b_second_hi", 64'(hi), 64'd0);

    repeat (3) next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
